// File: rtl/csi2_video_gate.sv
// csi2_video_gate: frame-aligned gate and FIFO between a non-stallable CSI-2 video source and a back-pressuring AXI-Stream sink.
//   clk_i/rst_i                   : clock, synchronous active-high reset
//   enable_i, clear_stat_i        : gate enable, drop-counter clear
//   video_t{valid,data,user,last}_i : upstream beats (no tready)
//   video_t{valid,ready,data,user,last}_o/_i : downstream show-ahead stream
//   overflow_stb_o, dropped_frames_o, fifo_used_o : overflow pulse, saturating drop count, fill level
module csi2_video_gate #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          clear_stat_i,
  input  logic                          video_tvalid_i,
  input  logic [DATA_WIDTH-1:0]         video_tdata_i,
  input  logic                          video_tuser_i,
  input  logic                          video_tlast_i,
  output logic                          video_tvalid_o,
  input  logic                          video_tready_i,
  output logic [DATA_WIDTH-1:0]         video_tdata_o,
  output logic                          video_tuser_o,
  output logic                          video_tlast_o,
  output logic                          overflow_stb_o,
  output logic [15:0]                   dropped_frames_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_used_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
  state_t r_state, w_state_nxt;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0] r_used;
  logic [15:0] r_drop;
  logic r_ovf, w_full, w_empty, w_wr, w_pop, w_ovf, w_sof, w_stop;
  // full comes from the registered level, so a same-cycle pop never frees a slot for the incoming beat
  assign w_full = r_used == (AW+1)'(FIFO_DEPTH);
  assign w_empty = r_used == '0;
  assign w_pop = !w_empty && video_tready_i;
  assign w_sof = video_tvalid_i && video_tuser_i;
  // a new frame seen while disabled closes the gate at the frame boundary
  assign w_stop = w_sof && !enable_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: w_state_nxt = (w_sof && enable_i && !w_full) ? PASS : IDLE;
      PASS: w_state_nxt = w_stop ? IDLE : (video_tvalid_i && w_full) ? DROP : PASS;
      DROP: w_state_nxt = w_stop ? IDLE : (w_sof && !w_full) ? PASS : DROP;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    w_wr = 1'b0;
    w_ovf = 1'b0;
    case (r_state)
      IDLE: w_wr = w_sof && enable_i && !w_full;
      PASS: begin
        w_wr = video_tvalid_i && !w_stop && !w_full;
        w_ovf = video_tvalid_i && !w_stop && w_full;
      end
      DROP: w_wr = w_sof && enable_i && !w_full;
      default: w_wr = 1'b0;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wr_ptr] <= {video_tuser_i, video_tlast_i, video_tdata_i};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used <= '0;
      r_ovf <= 1'b0;
      r_drop <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_used <= r_used + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_ovf <= w_ovf;
      r_drop <= clear_stat_i ? '0 : (w_ovf && r_drop != 16'hFFFF) ? r_drop + 1'b1 : r_drop;
    end
  end
  assign video_tvalid_o = !w_empty;
  // outputs forced to zero while empty so reset leaves a clean, defined bus
  assign {video_tuser_o, video_tlast_o, video_tdata_o} = w_empty ? '0 : r_mem[r_rd_ptr];
  assign overflow_stb_o = r_ovf;
  assign dropped_frames_o = r_drop;
  assign fifo_used_o = r_used;
endmodule

// File: tb/tb_csi2_video_gate.sv
// tb_csi2_video_gate: scoreboard bench for csi2_video_gate against a queue-based frame-gating model.
module tb_csi2_video_gate;
  localparam int DW = 16;
  localparam int DEPTH = 64;
  localparam int UW = $clog2(DEPTH) + 1;
  logic clk = 1'b0;
  logic rst, en, clr, v, u, l, rdy;
  logic [DW-1:0] d;
  logic vo, uo, lo, stb;
  logic [DW-1:0] dout;
  logic [15:0] drop;
  logic [UW-1:0] used;
  int checks = 0;
  int errors = 0;
  int m_cnt, m_state, m_drop;
  bit m_stb, mf, mw, mo, mp;
  logic [DW+1:0] exp_q [$];
  logic [DW+1:0] prev;
  bit prev_hold = 0;
  always #5 clk = ~clk;
  csi2_video_gate #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_stat_i(clr),
    .video_tvalid_i(v), .video_tdata_i(d), .video_tuser_i(u), .video_tlast_i(l),
    .video_tvalid_o(vo), .video_tready_i(rdy), .video_tdata_o(dout),
    .video_tuser_o(uo), .video_tlast_o(lo), .overflow_stb_o(stb),
    .dropped_frames_o(drop), .fifo_used_o(used)
  );
  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  // model: states 0=waiting for frame start, 1=forwarding, 2=discarding aborted frame
  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_state = 0; m_stb = 0; m_drop = 0;
      exp_q.delete();
    end else begin
      mf = (m_cnt == DEPTH);
      mp = (m_cnt > 0) && rdy;
      mw = 0; mo = 0;
      if (v) begin
        if (m_state == 0) begin
          if (u && en && !mf) begin mw = 1; m_state = 1; end
        end else if (m_state == 1) begin
          if (u && !en) m_state = 0;
          else if (mf) begin mo = 1; m_state = 2; end
          else mw = 1;
        end else if (u) begin
          if (!en) m_state = 0;
          else if (!mf) begin mw = 1; m_state = 1; end
        end
      end
      m_stb = mo;
      m_drop = clr ? 0 : (mo && m_drop < 65535) ? m_drop + 1 : m_drop;
      m_cnt = m_cnt + int'(mw) - int'(mp);
      if (mw) exp_q.push_back({u, l, d});
    end
  end
  always @(negedge clk) begin
    chk("used", longint'(used), longint'(m_cnt));
    chk("valid", longint'(vo), longint'(m_cnt != 0));
    chk("ovf_stb", longint'(stb), longint'(m_stb));
    chk("dropped", longint'(drop), longint'(m_drop));
    if (prev_hold && vo) chk("stable", longint'({uo, lo, dout}), longint'(prev));
    prev_hold = vo && !rdy;
    prev = {uo, lo, dout};
    if (vo && rdy) begin
      if (exp_q.size() == 0) chk("unexpected_beat", longint'({uo, lo, dout}), -1);
      else chk("beat", longint'({uo, lo, dout}), longint'(exp_q.pop_front()));
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input bit iv, input bit iu, input bit il, input bit ir);
    v = iv; u = iu; l = il; rdy = ir; d = DW'($urandom);
    tick();
  endtask
  task automatic frame(input int beats, input int bpl, input int start, input bit ir);
    for (int b = start; b < beats; b++) send(1, b == 0, (b % bpl) == bpl - 1, ir);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 0, 1);
  endtask
  task automatic reset_chk;
    rst = 1; send(1, 1, 0, 0);
    rst = 0;
    chk("rst_valid", longint'(vo), 0);
    chk("rst_used", longint'(used), 0);
    chk("rst_data", longint'({uo, lo, dout}), 0);
    chk("rst_stb", longint'(stb), 0);
    chk("rst_drop", longint'(drop), 0);
  endtask
  initial begin
    rst = 1; en = 1; clr = 0; v = 0; u = 0; l = 0; rdy = 0; d = '0;
    tick(); tick();
    reset_chk();
    frame(32, 8, 0, 1);
    idle(5);
    chk("pass_drop", longint'(drop), 0);
    reset_chk();
    frame(32, 32, 5, 1);
    frame(32, 32, 0, 1);
    idle(5);
    frame(100, 25, 0, 0);
    chk("ovf_used", longint'(used), 64);
    chk("ovf_count", longint'(drop), 1);
    idle(70);
    frame(16, 8, 0, 1);
    idle(5);
    frame(64, 16, 0, 0);
    send(1, 0, 0, 1);
    chk("full_pop_used", longint'(used), 63);
    idle(70);
    for (int b = 0; b < 16; b++) begin
      en = b < 6;
      send(1, b == 0, b % 8 == 7, 1);
    end
    frame(16, 8, 0, 1);
    chk("disabled_empty", longint'(used), 0);
    en = 1;
    frame(16, 8, 0, 1);
    idle(5);
    frame(65, 65, 0, 0);
    force dut.r_drop = 16'hFFFD;
    m_drop = 16'hFFFD;
    #1 release dut.r_drop;
    send(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 0, 0);
      send(1, 0, 0, 1);
    end
    chk("saturated", longint'(drop), 16'hFFFF);
    send(1, 1, 0, 0);
    clr = 1; send(1, 0, 0, 1);
    clr = 0;
    chk("clear_wins", longint'(drop), 0);
    idle(70);
    frame(10, 8, 0, 0);
    chk("pre_rst_used", longint'(used), 10);
    reset_chk();
    frame(16, 8, 3, 1);
    chk("post_rst_idle", longint'(vo), 0);
    frame(8, 8, 0, 1);
    idle(5);
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 16) != 0;
      clr = ($urandom % 200) == 0;
      rst = ($urandom % 997) == 0;
      send(($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 8) == 0, ($urandom % 3) != 0);
    end
    rst = 0; clr = 0; en = 1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    chk("drained", longint'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
